// File: rtl/little_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// little_cpu_ctrl
//
// Control sequencer for the little CPU datapath. A Moore-style FSM walks the
// fetch / decode / execute cycle. Its outputs are combinational decodes of the
// state register and the IR opcode field.
//
// Build option:
//   LITTLE_CPU_CTRL_WAIT_EN - when defined, F1 and E1 hold while i_mem_ready
//                             is low. When undefined, i_mem_ready is ignored
//                             and every state lasts exactly one cycle.
//
// Parameters:
//   OPC_W     opcode field width (IR[15:12])
//   ALU_OP_W  ALU operation select width
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous reset, active low
//   i_ir_opcode  opcode field of the instruction register
//   i_acc_zero   accumulator == 0
//   i_mem_ready  memory access complete (wait-state builds only)
//   o_pc_inc     increment PC
//   o_pc_load    load PC from IR operand
//   o_ir_load    load IR from MDR
//   o_mar_sel    MAR source: 0 = PC, 1 = IR operand
//   o_mar_load   load MAR
//   o_mdr_load   load MDR from memory read data
//   o_mem_we     memory write strobe (data = accumulator)
//   o_alu_sel    ALU B operand: 0 = MDR, 1 = IR operand
//   o_alu_op     ALU operation select
//   o_acc_load   load accumulator from ALU result
//   o_halted     CPU stopped on HLT
//   o_illegal    single-cycle pulse on an undefined opcode in DEC
//   o_state      current state encoding (debug)
// ---------------------------------------------------------------------------
module little_cpu_ctrl #(
    parameter int unsigned OPC_W    = 4,
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [OPC_W-1:0]    i_ir_opcode,
    input  logic                i_acc_zero,
    input  logic                i_mem_ready,
    output logic                o_pc_inc,
    output logic                o_pc_load,
    output logic                o_ir_load,
    output logic                o_mar_sel,
    output logic                o_mar_load,
    output logic                o_mdr_load,
    output logic                o_mem_we,
    output logic                o_alu_sel,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_acc_load,
    output logic                o_halted,
    output logic                o_illegal,
    output logic [3:0]          o_state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_E0   = 4'd5,
        S_E1   = 4'd6,
        S_E2   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_LDI = 4'h2,
        OP_STA = 4'h3,
        OP_ADD = 4'h4,
        OP_SUB = 4'h5,
        OP_AND = 4'h6,
        OP_OR  = 4'h7,
        OP_XOR = 4'h8,
        OP_JMP = 4'h9,
        OP_JZ  = 4'hA,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_XOR    = 3'd5
    } alu_op_e;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] opc;
    logic       mem_rdy;

    assign opc = 4'(i_ir_opcode);

`ifdef LITTLE_CPU_CTRL_WAIT_EN
    assign mem_rdy = i_mem_ready;
`else
    // Without wait states memory always completes in one cycle.
    logic unused_mem_ready;
    assign unused_mem_ready = i_mem_ready;
    assign mem_rdy          = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_pc_inc   = 1'b0;
        o_pc_load  = 1'b0;
        o_ir_load  = 1'b0;
        o_mar_sel  = 1'b0;
        o_mar_load = 1'b0;
        o_mdr_load = 1'b0;
        o_mem_we   = 1'b0;
        o_alu_sel  = 1'b0;
        o_alu_op   = '0;
        o_acc_load = 1'b0;
        o_halted   = 1'b0;
        o_illegal  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_F0;
            end

            S_F0: begin
                o_mar_load = 1'b1;
                state_d    = S_F1;
            end

            S_F1: begin
                if (mem_rdy) begin
                    o_mdr_load = 1'b1;
                    state_d    = S_F2;
                end
            end

            S_F2: begin
                o_ir_load = 1'b1;
                o_pc_inc  = 1'b1;
                state_d   = S_DEC;
            end

            S_DEC: begin
                case (opc)
                    OP_NOP: state_d = S_F0;
                    OP_LDA, OP_STA, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_XOR: state_d = S_E0;
                    OP_LDI: state_d = S_E2;
                    OP_JMP: begin
                        o_pc_load = 1'b1;
                        state_d   = S_F0;
                    end
                    OP_JZ: begin
                        o_pc_load = i_acc_zero;
                        state_d   = S_F0;
                    end
                    OP_HLT: state_d = S_HALT;
                    default: begin
                        // Undefined opcodes B..E behave as NOP but are flagged.
                        o_illegal = 1'b1;
                        state_d   = S_F0;
                    end
                endcase
            end

            S_E0: begin
                o_mar_sel  = 1'b1;
                o_mar_load = 1'b1;
                state_d    = S_E1;
            end

            S_E1: begin
                if (opc == OP_STA) begin
                    // Write strobe is held through every wait cycle.
                    o_mem_we = 1'b1;
                    if (mem_rdy) begin
                        state_d = S_F0;
                    end
                end else if (mem_rdy) begin
                    o_mdr_load = 1'b1;
                    state_d    = S_E2;
                end
            end

            S_E2: begin
                o_acc_load = 1'b1;
                o_alu_sel  = (opc == OP_LDI);
                case (opc)
                    OP_ADD:  o_alu_op = ALU_OP_W'(ALU_ADD);
                    OP_SUB:  o_alu_op = ALU_OP_W'(ALU_SUB);
                    OP_AND:  o_alu_op = ALU_OP_W'(ALU_AND);
                    OP_OR:   o_alu_op = ALU_OP_W'(ALU_OR);
                    OP_XOR:  o_alu_op = ALU_OP_W'(ALU_XOR);
                    default: o_alu_op = ALU_OP_W'(ALU_PASS_B);
                endcase
                state_d = S_F0;
            end

            S_HALT: begin
                o_halted = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_little_cpu_ctrl.sv
module tb_little_cpu_ctrl;

    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_ir_opcode;
    logic       i_acc_zero;
    logic       i_mem_ready;
    logic       o_pc_inc;
    logic       o_pc_load;
    logic       o_ir_load;
    logic       o_mar_sel;
    logic       o_mar_load;
    logic       o_mdr_load;
    logic       o_mem_we;
    logic       o_alu_sel;
    logic [2:0] o_alu_op;
    logic       o_acc_load;
    logic       o_halted;
    logic       o_illegal;
    logic [3:0] o_state;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Output vector bit positions
    localparam logic [13:0] PCINC  = 14'h2000;
    localparam logic [13:0] PCLD   = 14'h1000;
    localparam logic [13:0] IRLD   = 14'h0800;
    localparam logic [13:0] MARSEL = 14'h0400;
    localparam logic [13:0] MARLD  = 14'h0200;
    localparam logic [13:0] MDRLD  = 14'h0100;
    localparam logic [13:0] MEMWE  = 14'h0080;
    localparam logic [13:0] ALUSEL = 14'h0040;
    localparam logic [13:0] ACCLD  = 14'h0004;
    localparam logic [13:0] HALTED = 14'h0002;
    localparam logic [13:0] ILL    = 14'h0001;

    little_cpu_ctrl #(.OPC_W(4), .ALU_OP_W(3)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ir_opcode (i_ir_opcode),
        .i_acc_zero  (i_acc_zero),
        .i_mem_ready (i_mem_ready),
        .o_pc_inc    (o_pc_inc),
        .o_pc_load   (o_pc_load),
        .o_ir_load   (o_ir_load),
        .o_mar_sel   (o_mar_sel),
        .o_mar_load  (o_mar_load),
        .o_mdr_load  (o_mdr_load),
        .o_mem_we    (o_mem_we),
        .o_alu_sel   (o_alu_sel),
        .o_alu_op    (o_alu_op),
        .o_acc_load  (o_acc_load),
        .o_halted    (o_halted),
        .o_illegal   (o_illegal),
        .o_state     (o_state)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [13:0] outs();
        return {o_pc_inc, o_pc_load, o_ir_load, o_mar_sel, o_mar_load,
                o_mdr_load, o_mem_we, o_alu_sel, o_alu_op, o_acc_load,
                o_halted, o_illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens a few ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st,
                             input logic [13:0] o);
        #1;
        check({tag, " state"}, 32'(o_state), 32'(st));
        check({tag, " outs"}, 32'(outs()), 32'(o));
    endtask

    // From F0, step through F1 and F2 into DEC.
    task automatic fetch_to_dec();
        tick(); tick(); tick();
    endtask

    int unsigned cnt;

    initial begin
        i_rst       = 1'b0;
        i_ir_opcode = 4'h0;
        i_acc_zero  = 1'b0;
        i_mem_ready = 1'b1;
        #3;
        expect_st("reset", 4'd0, 14'h0);
        tick(); tick();
        i_rst = 1'b1;
        expect_st("idle after release", 4'd0, 14'h0);

        // NOP: 0,1,2,3,4,1
        tick(); expect_st("nop F0", 4'd1, MARLD);
        tick(); expect_st("nop F1", 4'd2, MDRLD);
        tick(); expect_st("nop F2", 4'd3, PCINC | IRLD);
        tick(); expect_st("nop DEC", 4'd4, 14'h0);
        tick(); expect_st("nop F0 again", 4'd1, MARLD);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            if (o_pc_inc) cnt++;
        end
        check("pc_inc per 8 cycles", cnt, 2);
        check("nop loop end F0", 32'(o_state), 1);

        // ADD, 7 cycles F0 to F0
        i_ir_opcode = 4'h4;
        fetch_to_dec(); expect_st("add DEC", 4'd4, 14'h0);
        tick(); expect_st("add E0", 4'd5, MARSEL | MARLD);
        tick(); expect_st("add E1", 4'd6, MDRLD);
        tick(); expect_st("add E2", 4'd7, ACCLD | 14'h0008);
        tick(); expect_st("add back F0", 4'd1, MARLD);

        // SUB E2 op
        i_ir_opcode = 4'h5;
        fetch_to_dec(); tick(); tick(); tick();
        expect_st("sub E2", 4'd7, ACCLD | 14'h0010);
        tick();

        // XOR E2 op
        i_ir_opcode = 4'h8;
        fetch_to_dec(); tick(); tick(); tick();
        expect_st("xor E2", 4'd7, ACCLD | 14'h0028);
        tick();

        // LDA E2 uses PASS_B from MDR
        i_ir_opcode = 4'h1;
        fetch_to_dec(); tick(); tick(); tick();
        expect_st("lda E2", 4'd7, ACCLD);
        tick();

        // LDI: DEC -> E2 directly, immediate operand
        i_ir_opcode = 4'h2;
        fetch_to_dec();
        tick(); expect_st("ldi E2", 4'd7, ACCLD | ALUSEL);
        tick(); expect_st("ldi back F0", 4'd1, MARLD);

        // JZ taken / not taken
        i_ir_opcode = 4'hA;
        i_acc_zero  = 1'b1;
        fetch_to_dec(); expect_st("jz taken DEC", 4'd4, PCLD);
        tick(); expect_st("jz taken F0", 4'd1, MARLD);
        i_acc_zero = 1'b0;
        fetch_to_dec(); expect_st("jz not taken DEC", 4'd4, 14'h0);
        tick(); expect_st("jz not taken F0", 4'd1, MARLD);

        // JMP
        i_ir_opcode = 4'h9;
        fetch_to_dec(); expect_st("jmp DEC", 4'd4, PCLD);
        tick(); expect_st("jmp F0", 4'd1, MARLD);

        // STA
        i_ir_opcode = 4'h3;
        fetch_to_dec();
        tick(); expect_st("sta E0", 4'd5, MARSEL | MARLD);
`ifdef LITTLE_CPU_CTRL_WAIT_EN
        i_mem_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            if (o_mem_we && o_state == 4'd6) cnt++;
        end
        i_mem_ready = 1'b1;
        #1;
        if (o_mem_we && o_state == 4'd6) cnt++;
        check("sta we cycles", cnt, 4);
        tick(); expect_st("sta wait back F0", 4'd1, MARLD);
`else
        tick(); expect_st("sta E1", 4'd6, MEMWE);
        tick(); expect_st("sta back F0", 4'd1, MARLD);
`endif

        // Illegal opcode C
        i_ir_opcode = 4'hC;
        fetch_to_dec(); expect_st("illegal DEC", 4'd4, ILL);
        tick(); expect_st("illegal F0", 4'd1, MARLD);

        // Async reset in E1
        i_ir_opcode = 4'h4;
        fetch_to_dec(); tick(); tick();
        expect_st("pre-reset E1", 4'd6, MDRLD);
        i_rst = 1'b0;
        #1;
        expect_st("async reset", 4'd0, 14'h0);
        i_rst = 1'b1;
        tick(); expect_st("after reset F0", 4'd1, MARLD);

        // HLT
        i_ir_opcode = 4'hF;
        fetch_to_dec(); expect_st("hlt DEC", 4'd4, 14'h0);
        tick(); expect_st("halt", 4'd8, HALTED);
        i_ir_opcode = 4'h0;
        cnt = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            #1;
            if (o_state == 4'd8 && o_halted) cnt++;
        end
        check("halt hold cycles", cnt, 22);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/little_cpu_ctrl.md
# little_cpu_ctrl

Control sequencer for the little CPU datapath: a Moore-style state machine that walks the fetch/decode/execute cycle. It drives the program counter, instruction register, MAR/MDR, memory write strobe, the PC/IR address mux, the ALU operand mux, the ALU opcode and the accumulator load. The block sits beside the datapath in `little_cpu` and reads back only the IR opcode field, the accumulator-zero flag and the memory ready strobe.

## Interface
- `OPC_W`, 4, instruction opcode field width (IR[15:12])
- `ALU_OP_W`, 3, ALU operation select width
- `i_clk`  in  1  system clock, all state changes on rising edge
- `i_rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `i_ir_opcode`  in  OPC_W  opcode field of instruction register
- `i_acc_zero`  in  1  accumulator == 0 flag
- `i_mem_ready`  in  1  memory access complete (used only with wait states enabled)
- `o_pc_inc`  out  1  increment program counter
- `o_pc_load`  out  1  load PC from IR operand (jump)
- `o_ir_load`  out  1  load IR from MDR
- `o_mar_sel`  out  1  MAR source mux: 0 = PC, 1 = IR operand
- `o_mar_load`  out  1  load MAR
- `o_mdr_load`  out  1  load MDR from memory read data
- `o_mem_we`  out  1  memory write strobe (data = accumulator)
- `o_alu_sel`  out  1  ALU B-operand mux: 0 = MDR, 1 = IR operand (immediate)
- `o_alu_op`  out  ALU_OP_W  0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
- `o_acc_load`  out  1  load accumulator from ALU result
- `o_halted`  out  1  CPU stopped on HLT
- `o_illegal`  out  1  one-cycle pulse when an undefined opcode is decoded
- `o_state`  out  4  current state encoding, for debug

## Operation
- States: IDLE(0), F0(1), F1(2), F2(3), DEC(4), E0(5), E1(6), E2(7), HALT(8).
- IDLE: all outputs 0. Always advances to F0. Entered only from reset.
- F0: `o_mar_sel`=0, `o_mar_load`=1. Next is F1.
- F1: `o_mdr_load`=1. Next is F2.
- F2: `o_ir_load`=1, `o_pc_inc`=1. Next is DEC.
- DEC decodes `i_ir_opcode`:
  - 0 NOP: next is F0.
  - 1 LDA, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR: next is E0.
  - 2 LDI: next is E2.
  - 3 STA: next is E0.
  - 9 JMP: `o_pc_load`=1; next is F0.
  - A JZ: `o_pc_load`=`i_acc_zero`; next is F0.
  - F HLT: next is HALT.
  - B–E: `o_illegal`=1; treated as NOP; next is F0.
- E0: `o_mar_sel`=1, `o_mar_load`=1. Next is E1.
- E1:
  - STA: `o_mem_we`=1; next is F0.
  - Other opcodes: `o_mdr_load`=1; next is E2.
- E2: `o_acc_load`=1.
  - `o_alu_sel`=1 for LDI, else 0.
  - `o_alu_op` mapping: LDA and LDI → PASS_B; ADD→1; SUB→2; AND→3; OR→4; XOR→5.
  - Next is F0.
- Outside E2, `o_alu_op`=0 and `o_alu_sel`=0.
- HALT: `o_halted`=1, all other outputs 0. Stays in HALT until reset.
- Opcode is read directly from IR. IR loads only in F2, so it is stable from DEC through E2.
- Outputs are combinational decodes of the state register and `i_ir_opcode`. Outputs not listed for a state are 0.

## Timing
- Reset:
  - `i_rst`=0 forces IDLE asynchronously, mid-instruction included. All outputs go to 0 immediately (`o_state`=0).
  - First rising edge with `i_rst`=1 moves to F0.
- Instruction latency in cycles, without wait states:
  - NOP, JMP, JZ, illegal: 4.
  - LDI: 5.
  - STA: 6.
  - LDA and ALU ops: 7.
  - HLT: 4 cycles to HALT.
- JMP/JZ: in DEC, `o_pc_load` overrides the PC increment already applied in F2. The next F0 fetches from the jump target.
- PC increment and PC load are never asserted in the same cycle.
- `o_mem_we` and `o_mdr_load` are never asserted in the same cycle.

## Configuration
- `LITTLE_CPU_CTRL_WAIT_EN` defined (memory wait states on):
  - F1 and E1 hold while `i_mem_ready`=0.
  - `o_mdr_load` asserts only in the cycle where `i_mem_ready`=1.
  - `o_mem_we` stays asserted for every E1 cycle of STA until `i_mem_ready`=1.
  - Each wait cycle adds 1 to the latency figures above.
- Macro undefined: `i_mem_ready` is ignored, and F1/E1 always last exactly one cycle.

## Test plan
- Reset, then release; IR opcode 0 (NOP) → `o_state` sequence 0,1,2,3,4,1. Exactly one `o_pc_inc` pulse per 4 cycles after IDLE.
- Opcode 4 (ADD) → E0 has `o_mar_sel`=1 and `o_mar_load`=1. E1 has `o_mdr_load`=1. E2 has `o_alu_op`=1, `o_alu_sel`=0, `o_acc_load`=1. Back to F0 7 cycles after the previous F0.
- Opcode A (JZ) with `i_acc_zero`=1 → `o_pc_load`=1 in DEC. With `i_acc_zero`=0 → `o_pc_load`=0 and the next state is F0.
- Opcode 3 (STA) with WAIT_EN and `i_mem_ready` low for 3 cycles in E1 → `o_mem_we` high for 4 consecutive cycles, then F0.
- Opcode C → `o_illegal` high exactly one cycle (in DEC), then F0. Opcode F → `o_halted`=1 and the FSM stays in HALT for 20+ cycles.
- Assert `i_rst`=0 while in E1 → `o_state`=0 and all outputs 0 before the next clock edge. Release → F0.
